cp0_exc_arbiter: RTL and testbench

- Sits between the two memory-stage slots of the dual-issue pipeline and CP0.
- Picks at most one exception, interrupt or ERET per cycle and builds the CP0 interrupt control words.
- Serialises simultaneous MTC0 writes from both slots onto the CP0 write ports.
- Drives pipeline flush, stall and PC redirect for exception entry and ERET return.

---
 rtl/cp0_exc_arbiter.sv | 225 ++++++++++++++++++++++
 tb/tb_cp0_exc_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_exc_arbiter.sv
// cp0_exc_arbiter
//   Arbitrates the two memory-stage slots of the dual-issue pipeline onto CP0.
//   It picks at most one interrupt, exception or ERET per cycle and builds the
//   CP0 interrupt control words. It serialises simultaneous MTC0 writes onto
//   the two CP0 write ports, and drives flush, stall and PC redirect.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | sampling slot inputs, arbitrating exceptions and writes
//   WR2   | issuing the latched slot 2 MTC0 on port 2, upstream stalled
//   FLUSH | pipeline flush in progress, slot inputs ignored
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   slot{1,2}_valid_i          slot holds a live instruction (slot 1 is older)
//   slot{1,2}_exc_i            exception flags, lowest set bit has priority
//   slot{1,2}_bd_i/_pc_i/_badva_i  delay-slot flag, PC, faulting address
//   slot{1,2}_wen_i/_waddr_i/_wdata_i  MTC0 request
//   int_pending_i, exl_i, epc_i  interrupt pending, Status.EXL, EPC
//   cp0_*_{1,2}                registered CP0 control words, PCs, writes
//   flush_o, stall_o           pipeline kill and upstream hold
//   redirect_valid_o/_pc_o     one-cycle redirect pulse and target
module cp0_exc_arbiter #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        slot1_valid_i,
  input  logic        slot2_valid_i,
  input  logic [7:0]  slot1_exc_i,
  input  logic [7:0]  slot2_exc_i,
  input  logic        slot1_bd_i,
  input  logic        slot2_bd_i,
  input  logic [31:0] slot1_pc_i,
  input  logic [31:0] slot2_pc_i,
  input  logic [31:0] slot1_badva_i,
  input  logic [31:0] slot2_badva_i,
  input  logic        slot1_wen_i,
  input  logic        slot2_wen_i,
  input  logic [4:0]  slot1_waddr_i,
  input  logic [4:0]  slot2_waddr_i,
  input  logic [31:0] slot1_wdata_i,
  input  logic [31:0] slot2_wdata_i,
  input  logic        int_pending_i,
  input  logic        exl_i,
  input  logic [31:0] epc_i,
  output logic [15:0] cp0_int_contr_word_1,
  output logic [15:0] cp0_int_contr_word_2,
  output logic [31:0] cp0_pc_1,
  output logic [31:0] cp0_pc_2,
  output logic [31:0] cp0_badva_1,
  output logic [31:0] cp0_badva_2,
  output logic        cp0_w_en_1,
  output logic        cp0_w_en_2,
  output logic [4:0]  cp0_w_addr_1,
  output logic [4:0]  cp0_w_addr_2,
  output logic [31:0] cp0_w_data_1,
  output logic [31:0] cp0_w_data_2,
  output logic        flush_o,
  output logic        stall_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o
);

  typedef enum logic [1:0] {IDLE, WR2, FLUSH} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);
  localparam logic [7:0] ERET_FLAG = 8'h40;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [4:0]  pend_addr, pend_addr_nxt;
  logic [31:0] pend_data, pend_data_nxt;

  logic [15:0] word1_nxt, word2_nxt;
  logic [31:0] pc1_nxt, pc2_nxt, ba1_nxt, ba2_nxt;
  logic        wen1_nxt, wen2_nxt;
  logic [4:0]  waddr1_nxt, waddr2_nxt;
  logic [31:0] wdata1_nxt, wdata2_nxt;
  logic        rv_nxt;
  logic [31:0] rpc_nxt;

  logic [7:0]  onehot1, onehot2, flag1;
  logic        int_take, exc1_take, exc2_take, sel1, sel2, wr1, wr2;

  // Two's-complement trick isolates the lowest set flag bit.
  assign onehot1 = slot1_exc_i & (~slot1_exc_i + 8'd1);
  assign onehot2 = slot2_exc_i & (~slot2_exc_i + 8'd1);

  assign int_take  = int_pending_i & ~exl_i & slot1_valid_i;
  assign exc1_take = slot1_valid_i & (slot1_exc_i != 8'd0);
  assign exc2_take = slot2_valid_i & (slot2_exc_i != 8'd0);

  // Slot 1 (older) pre-empts slot 2; an interrupt is reported with a zero flag.
  assign sel1  = int_take | exc1_take;
  assign sel2  = ~sel1 & exc2_take;
  assign flag1 = int_take ? 8'h00 : onehot1;

  // An interrupted or excepting slot 1 kills both writes; slot 2 kills its own.
  assign wr1 = slot1_valid_i & slot1_wen_i & ~sel1;
  assign wr2 = slot2_valid_i & slot2_wen_i & ~sel1 & ~exc2_take;

  assign stall_o = (state == WR2);

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    pend_addr_nxt = pend_addr;
    pend_data_nxt = pend_data;
    word1_nxt     = 16'h0000;
    word2_nxt     = 16'h0000;
    pc1_nxt       = cp0_pc_1;
    pc2_nxt       = cp0_pc_2;
    ba1_nxt       = cp0_badva_1;
    ba2_nxt       = cp0_badva_2;
    wen1_nxt      = 1'b0;
    wen2_nxt      = 1'b0;
    waddr1_nxt    = cp0_w_addr_1;
    waddr2_nxt    = cp0_w_addr_2;
    wdata1_nxt    = cp0_w_data_1;
    wdata2_nxt    = cp0_w_data_2;
    rv_nxt        = 1'b0;
    rpc_nxt       = redirect_pc_o;

    case (state)
      IDLE: begin
        if (sel1) begin
          word1_nxt = {1'b1, 6'b0, slot1_bd_i, flag1};
          pc1_nxt   = slot1_pc_i;
          ba1_nxt   = slot1_badva_i;
          rv_nxt    = 1'b1;
          rpc_nxt   = (flag1 == ERET_FLAG) ? epc_i : EXC_VECTOR;
          state_nxt = FLUSH;
          cnt_nxt   = CNT_LOAD;
        end else if (sel2) begin
          word2_nxt = {1'b1, 6'b0, slot2_bd_i, onehot2};
          pc2_nxt   = slot2_pc_i;
          ba2_nxt   = slot2_badva_i;
          rv_nxt    = 1'b1;
          rpc_nxt   = (onehot2 == ERET_FLAG) ? epc_i : EXC_VECTOR;
          state_nxt = FLUSH;
          cnt_nxt   = CNT_LOAD;
        end

        if (wr1) begin
          wen1_nxt   = 1'b1;
          waddr1_nxt = slot1_waddr_i;
          wdata1_nxt = slot1_wdata_i;
        end

        // A write pair can never coincide with a selection, so WR2 and
        // FLUSH are mutually exclusive here.
        if (wr1 && wr2) begin
          pend_addr_nxt = slot2_waddr_i;
          pend_data_nxt = slot2_wdata_i;
          state_nxt     = WR2;
        end else if (wr2) begin
          wen2_nxt   = 1'b1;
          waddr2_nxt = slot2_waddr_i;
          wdata2_nxt = slot2_wdata_i;
        end
      end

      WR2: begin
        wen2_nxt   = 1'b1;
        waddr2_nxt = pend_addr;
        wdata2_nxt = pend_data;
        state_nxt  = IDLE;
      end

      FLUSH: begin
        if (cnt == 4'd0) state_nxt = IDLE;
        else             cnt_nxt   = cnt - 4'd1;
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state                <= IDLE;
      cnt                  <= 4'd0;
      pend_addr            <= 5'd0;
      pend_data            <= 32'd0;
      cp0_int_contr_word_1 <= 16'h0000;
      cp0_int_contr_word_2 <= 16'h0000;
      cp0_pc_1             <= 32'd0;
      cp0_pc_2             <= 32'd0;
      cp0_badva_1          <= 32'd0;
      cp0_badva_2          <= 32'd0;
      cp0_w_en_1           <= 1'b0;
      cp0_w_en_2           <= 1'b0;
      cp0_w_addr_1         <= 5'd0;
      cp0_w_addr_2         <= 5'd0;
      cp0_w_data_1         <= 32'd0;
      cp0_w_data_2         <= 32'd0;
      flush_o              <= 1'b0;
      redirect_valid_o     <= 1'b0;
      redirect_pc_o        <= 32'd0;
    end else begin
      state                <= state_nxt;
      cnt                  <= cnt_nxt;
      pend_addr            <= pend_addr_nxt;
      pend_data            <= pend_data_nxt;
      cp0_int_contr_word_1 <= word1_nxt;
      cp0_int_contr_word_2 <= word2_nxt;
      cp0_pc_1             <= pc1_nxt;
      cp0_pc_2             <= pc2_nxt;
      cp0_badva_1          <= ba1_nxt;
      cp0_badva_2          <= ba2_nxt;
      cp0_w_en_1           <= wen1_nxt;
      cp0_w_en_2           <= wen2_nxt;
      cp0_w_addr_1         <= waddr1_nxt;
      cp0_w_addr_2         <= waddr2_nxt;
      cp0_w_data_1         <= wdata1_nxt;
      cp0_w_data_2         <= wdata2_nxt;
      flush_o              <= (state_nxt == FLUSH);
      redirect_valid_o     <= rv_nxt;
      redirect_pc_o        <= rpc_nxt;
    end
  end

endmodule

// File: tb/tb_cp0_exc_arbiter.sv
module tb_cp0_exc_arbiter;

  localparam logic [31:0] VEC = 32'hBFC0_0380;

  logic        clk = 1'b0;
  logic        reset;
  logic        slot1_valid_i, slot2_valid_i;
  logic [7:0]  slot1_exc_i, slot2_exc_i;
  logic        slot1_bd_i, slot2_bd_i;
  logic [31:0] slot1_pc_i, slot2_pc_i, slot1_badva_i, slot2_badva_i;
  logic        slot1_wen_i, slot2_wen_i;
  logic [4:0]  slot1_waddr_i, slot2_waddr_i;
  logic [31:0] slot1_wdata_i, slot2_wdata_i;
  logic        int_pending_i, exl_i;
  logic [31:0] epc_i;
  logic [15:0] cp0_int_contr_word_1, cp0_int_contr_word_2;
  logic [31:0] cp0_pc_1, cp0_pc_2, cp0_badva_1, cp0_badva_2;
  logic        cp0_w_en_1, cp0_w_en_2;
  logic [4:0]  cp0_w_addr_1, cp0_w_addr_2;
  logic [31:0] cp0_w_data_1, cp0_w_data_2;
  logic        flush_o, stall_o, redirect_valid_o;
  logic [31:0] redirect_pc_o;

  cp0_exc_arbiter #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .slot1_valid_i(slot1_valid_i), .slot2_valid_i(slot2_valid_i),
    .slot1_exc_i(slot1_exc_i), .slot2_exc_i(slot2_exc_i),
    .slot1_bd_i(slot1_bd_i), .slot2_bd_i(slot2_bd_i),
    .slot1_pc_i(slot1_pc_i), .slot2_pc_i(slot2_pc_i),
    .slot1_badva_i(slot1_badva_i), .slot2_badva_i(slot2_badva_i),
    .slot1_wen_i(slot1_wen_i), .slot2_wen_i(slot2_wen_i),
    .slot1_waddr_i(slot1_waddr_i), .slot2_waddr_i(slot2_waddr_i),
    .slot1_wdata_i(slot1_wdata_i), .slot2_wdata_i(slot2_wdata_i),
    .int_pending_i(int_pending_i), .exl_i(exl_i), .epc_i(epc_i),
    .cp0_int_contr_word_1(cp0_int_contr_word_1), .cp0_int_contr_word_2(cp0_int_contr_word_2),
    .cp0_pc_1(cp0_pc_1), .cp0_pc_2(cp0_pc_2),
    .cp0_badva_1(cp0_badva_1), .cp0_badva_2(cp0_badva_2),
    .cp0_w_en_1(cp0_w_en_1), .cp0_w_en_2(cp0_w_en_2),
    .cp0_w_addr_1(cp0_w_addr_1), .cp0_w_addr_2(cp0_w_addr_2),
    .cp0_w_data_1(cp0_w_data_1), .cp0_w_data_2(cp0_w_data_2),
    .flush_o(flush_o), .stall_o(stall_o),
    .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o)
  );

  always #5 clk = ~clk;

  // ctrl = {word_1, word_2, w_en_1, w_en_2, flush, stall, redirect_valid}
  typedef struct packed {
    logic [36:0] ctrl;
    logic [31:0] rpc;
    logic [31:0] pc1;
    logic [31:0] ba1;
    logic [31:0] pc2;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic [4:0]  a2;
    logic [31:0] d2;
  } snap_t;

  snap_t exp_q[$];
  snap_t obs_q[$];
  int n_checks = 0;
  int n_errors = 0;

  function automatic logic [36:0] ctl(logic [15:0] w1, logic [15:0] w2, logic we1,
                                      logic we2, logic fl, logic st, logic rv);
    return {w1, w2, we1, we2, fl, st, rv};
  endfunction

  task automatic idle();
    slot1_valid_i = 0; slot2_valid_i = 0; slot1_exc_i = 0; slot2_exc_i = 0;
    slot1_bd_i = 0; slot2_bd_i = 0; slot1_pc_i = 0; slot2_pc_i = 0;
    slot1_badva_i = 0; slot2_badva_i = 0; slot1_wen_i = 0; slot2_wen_i = 0;
    slot1_waddr_i = 0; slot2_waddr_i = 0; slot1_wdata_i = 0; slot2_wdata_i = 0;
    int_pending_i = 0; exl_i = 0; epc_i = 0;
  endtask

  task automatic push(logic [36:0] c);
    snap_t e;
    e = '0;
    e.ctrl = c;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    snap_t o;
    @(posedge clk); #1;
    o.ctrl = {cp0_int_contr_word_1, cp0_int_contr_word_2, cp0_w_en_1, cp0_w_en_2,
              flush_o, stall_o, redirect_valid_o};
    o.rpc = redirect_pc_o; o.pc1 = cp0_pc_1; o.ba1 = cp0_badva_1; o.pc2 = cp0_pc_2;
    o.a1 = cp0_w_addr_1; o.d1 = cp0_w_data_1; o.a2 = cp0_w_addr_2; o.d2 = cp0_w_data_2;
    obs_q.push_back(o);
  endtask

  task automatic test_reset();
    snap_t e, o;
    reset = 1; idle();
    push('0); tick();
    push('0); tick();
    reset = 0;
    push('0); tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_errors++;
        $display("FAIL reset_state: got %h want %h", o, e);
      end
    end
  endtask

  task automatic test_exception();
    snap_t e, o;
    idle();
    slot1_valid_i = 1; slot1_exc_i = 8'h04; slot1_pc_i = 32'h8000_1000;
    slot1_bd_i = 1; slot1_badva_i = 32'h1234_5678;
    e = '0; e.ctrl = ctl(16'h8104, 0, 0, 0, 1, 0, 1); e.rpc = VEC;
    e.pc1 = 32'h8000_1000; e.ba1 = 32'h1234_5678;
    exp_q.push_back(e); tick();
    // live-looking traffic during the flush must be ignored
    idle(); slot1_valid_i = 1; slot1_wen_i = 1; slot1_waddr_i = 5'd12;
    slot2_valid_i = 1; slot2_exc_i = 8'h01;
    push(ctl(0, 0, 0, 0, 1, 0, 0)); tick();
    push(ctl(0, 0, 0, 0, 0, 0, 0)); tick();
    idle();
    push(ctl(0, 0, 0, 0, 0, 0, 0)); tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o.ctrl !== e.ctrl) begin
        n_errors++; $display("FAIL exc_ctrl: got %h want %h", o.ctrl, e.ctrl);
      end
      if (e.ctrl[0]) begin
        n_checks++;
        if ({o.rpc, o.pc1, o.ba1} !== {e.rpc, e.pc1, e.ba1}) begin
          n_errors++;
          $display("FAIL exc_pc: got rpc=%h pc1=%h ba1=%h want rpc=%h pc1=%h ba1=%h",
                   o.rpc, o.pc1, o.ba1, e.rpc, e.pc1, e.ba1);
        end
      end
    end
  endtask

  task automatic test_priority();
    snap_t e, o;
    idle();
    slot1_valid_i = 1; slot1_exc_i = 8'h12; slot1_wen_i = 1; slot1_waddr_i = 5'd3;
    slot2_valid_i = 1; slot2_exc_i = 8'h20; slot2_wen_i = 1; slot2_waddr_i = 5'd12;
    e = '0; e.ctrl = ctl(16'h8002, 0, 0, 0, 1, 0, 1); e.rpc = VEC;
    exp_q.push_back(e); tick();
    idle();
    push(ctl(0, 0, 0, 0, 1, 0, 0)); tick();
    push(ctl(0, 0, 0, 0, 0, 0, 0)); tick();
    // slot 2 alone, multi-bit flags reduce to the lowest one
    slot1_valid_i = 1; slot1_wen_i = 1; slot1_waddr_i = 5'd9; slot1_wdata_i = 32'hAA;
    slot2_valid_i = 1; slot2_exc_i = 8'h88; slot2_bd_i = 1; slot2_pc_i = 32'h8000_0300;
    e = '0; e.ctrl = ctl(0, 16'h8108, 1, 0, 1, 0, 1); e.rpc = VEC; e.pc2 = 32'h8000_0300;
    e.a1 = 5'd9; e.d1 = 32'hAA;
    exp_q.push_back(e); tick();
    idle();
    push(ctl(0, 0, 0, 0, 1, 0, 0)); tick();
    push(ctl(0, 0, 0, 0, 0, 0, 0)); tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o.ctrl !== e.ctrl) begin
        n_errors++; $display("FAIL prio_ctrl: got %h want %h", o.ctrl, e.ctrl);
      end
      if (e.ctrl[0]) begin
        n_checks++;
        if (o.rpc !== e.rpc) begin
          n_errors++; $display("FAIL prio_rpc: got %h want %h", o.rpc, e.rpc);
        end
      end
      if (e.ctrl[20]) begin
        n_checks++;
        if ({o.pc2, o.a1, o.d1} !== {e.pc2, e.a1, e.d1}) begin
          n_errors++;
          $display("FAIL prio_slot2: got pc2=%h a1=%0d d1=%h want pc2=%h a1=%0d d1=%h",
                   o.pc2, o.a1, o.d1, e.pc2, e.a1, e.d1);
        end
      end
    end
  endtask

  task automatic test_eret();
    snap_t e, o;
    idle();
    slot1_valid_i = 1; slot1_exc_i = 8'h40; slot1_pc_i = 32'h8000_0500; epc_i = 32'h8000_2000;
    e = '0; e.ctrl = ctl(16'h8040, 0, 0, 0, 1, 0, 1); e.rpc = 32'h8000_2000;
    e.pc1 = 32'h8000_0500;
    exp_q.push_back(e); tick();
    idle();
    push(ctl(0, 0, 0, 0, 1, 0, 0)); tick();
    push(ctl(0, 0, 0, 0, 0, 0, 0)); tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o.ctrl !== e.ctrl) begin
        n_errors++; $display("FAIL eret_ctrl: got %h want %h", o.ctrl, e.ctrl);
      end
      if (e.ctrl[0]) begin
        n_checks++;
        if ({o.rpc, o.pc1} !== {e.rpc, e.pc1}) begin
          n_errors++;
          $display("FAIL eret_pc: got rpc=%h pc1=%h want rpc=%h pc1=%h", o.rpc, o.pc1, e.rpc, e.pc1);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    snap_t e, o;
    idle();
    slot1_valid_i = 1; slot1_wen_i = 1; slot1_waddr_i = 5'd12; slot1_wdata_i = 32'h0000_FF01;
    slot2_valid_i = 1; slot2_wen_i = 1; slot2_waddr_i = 5'd11; slot2_wdata_i = 32'h100;
    e = '0; e.ctrl = ctl(0, 0, 1, 0, 0, 1, 0); e.a1 = 5'd12; e.d1 = 32'h0000_FF01;
    exp_q.push_back(e); tick();
    // inputs during WR2 are ignored
    idle(); slot1_valid_i = 1; slot1_exc_i = 8'h04; slot2_valid_i = 1; slot2_wen_i = 1;
    slot2_waddr_i = 5'd3;
    e = '0; e.ctrl = ctl(0, 0, 0, 1, 0, 0, 0); e.a2 = 5'd11; e.d2 = 32'h100;
    exp_q.push_back(e); tick();
    idle();
    push(ctl(0, 0, 0, 0, 0, 0, 0)); tick();
    // equal addresses still issue in order
    slot1_valid_i = 1; slot1_wen_i = 1; slot1_waddr_i = 5'd12; slot1_wdata_i = 32'h1;
    slot2_valid_i = 1; slot2_wen_i = 1; slot2_waddr_i = 5'd12; slot2_wdata_i = 32'h2;
    e = '0; e.ctrl = ctl(0, 0, 1, 0, 0, 1, 0); e.a1 = 5'd12; e.d1 = 32'h1;
    exp_q.push_back(e); tick();
    idle();
    e = '0; e.ctrl = ctl(0, 0, 0, 1, 0, 0, 0); e.a2 = 5'd12; e.d2 = 32'h2;
    exp_q.push_back(e); tick();
    // single slot 2 write goes straight to port 2
    slot2_valid_i = 1; slot2_wen_i = 1; slot2_waddr_i = 5'd5; slot2_wdata_i = 32'h55;
    e = '0; e.ctrl = ctl(0, 0, 0, 1, 0, 0, 0); e.a2 = 5'd5; e.d2 = 32'h55;
    exp_q.push_back(e); tick();
    idle();
    push(ctl(0, 0, 0, 0, 0, 0, 0)); tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o.ctrl !== e.ctrl) begin
        n_errors++; $display("FAIL b2b_ctrl: got %h want %h", o.ctrl, e.ctrl);
      end
      if (e.ctrl[4]) begin
        n_checks++;
        if ({o.a1, o.d1} !== {e.a1, e.d1}) begin
          n_errors++; $display("FAIL b2b_port1: got %0d/%h want %0d/%h", o.a1, o.d1, e.a1, e.d1);
        end
      end
      if (e.ctrl[3]) begin
        n_checks++;
        if ({o.a2, o.d2} !== {e.a2, e.d2}) begin
          n_errors++; $display("FAIL b2b_port2: got %0d/%h want %0d/%h", o.a2, o.d2, e.a2, e.d2);
        end
      end
    end
  endtask

  task automatic test_interrupt();
    snap_t e, o;
    for (int k = 0; k < 2; k++) begin
      idle();
      int_pending_i = 1; exl_i = (k == 1);
      slot1_valid_i = 1; slot1_exc_i = 8'h10; slot1_pc_i = 32'h8000_0040;
      slot2_valid_i = 1; slot2_wen_i = 1; slot2_waddr_i = 5'd4;
      e = '0; e.ctrl = ctl((k == 1) ? 16'h8010 : 16'h8000, 0, 0, 0, 1, 0, 1);
      e.rpc = VEC; e.pc1 = 32'h8000_0040;
      exp_q.push_back(e); tick();
      idle();
      push(ctl(0, 0, 0, 0, 1, 0, 0)); tick();
      push(ctl(0, 0, 0, 0, 0, 0, 0)); tick();
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o.ctrl !== e.ctrl) begin
        n_errors++; $display("FAIL int_ctrl: got %h want %h", o.ctrl, e.ctrl);
      end
      if (e.ctrl[0]) begin
        n_checks++;
        if ({o.rpc, o.pc1} !== {e.rpc, e.pc1}) begin
          n_errors++;
          $display("FAIL int_pc: got rpc=%h pc1=%h want rpc=%h pc1=%h", o.rpc, o.pc1, e.rpc, e.pc1);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    snap_t e, o;
    idle();
    slot1_valid_i = 1; slot1_wen_i = 1; slot1_waddr_i = 5'd12;
    slot2_valid_i = 1; slot2_wen_i = 1; slot2_waddr_i = 5'd11;
    push(ctl(0, 0, 1, 0, 0, 1, 0)); tick();
    idle(); reset = 1;
    push('0); tick();
    reset = 0;
    push('0); tick();
    slot1_valid_i = 1; slot1_exc_i = 8'h02;
    push(ctl(16'h8002, 0, 0, 0, 1, 0, 1)); tick();
    idle(); reset = 1;
    push('0); tick();
    reset = 0;
    push('0); tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o.ctrl !== e.ctrl) begin
        n_errors++; $display("FAIL reset_mid_ctrl: got %h want %h", o.ctrl, e.ctrl);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_exception();
    test_priority();
    test_eret();
    test_back_to_back();
    test_interrupt();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
